// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped transmit buffer between the core store path and
// a UART transmitter. Software pushes bytes into a DEPTH-entry FIFO through
// DATA. A small drain FSM hands them to the UART one at a time, using the
// UART's write_enable/busy handshake.
//
// Register block at BASE_ADDR:
//   +0 DATA   (W)  push write_data[7:0]; reads 0
//   +4 STATUS (R)  [0] full, [1] empty, [2] overflow (sticky), [3] draining,
//                  [16:8] count
//   +8 CTRL   (W)  bit0 flush FIFO, bit1 clear overflow; reads 0
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   address, write_data   core data address / store data
//   write_enable          core store strobe
//   read_data             combinational register readback
//   uart_data             byte presented to the UART (held between launches)
//   uart_write_enable     one-cycle launch strobe to the UART
//   uart_busy             UART transmitter busy
module uart_tx_fifo #(
    parameter int unsigned DEPTH        = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h1002_0000,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    output logic [31:0] read_data,
    output logic [7:0]  uart_data,
    output logic        uart_write_enable,
    input  logic        uart_busy
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(BUSY_TIMEOUT - 1);
    localparam logic [31:0]      ADDR_DATA = BASE_ADDR;
    localparam logic [31:0]      ADDR_STAT = BASE_ADDR + 32'd4;
    localparam logic [31:0]      ADDR_CTRL = BASE_ADDR + 32'd8;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       uart_data_q, uart_data_d;
    logic             uart_we_q, uart_we_d;
    logic [7:0]       mem_q [DEPTH];

    logic sel_data, sel_ctrl, flush, ovf_clr;
    logic full, empty, push_ok, push_drop, pop;
    logic unused_wdata;

    assign unused_wdata = ^write_data[31:8];

    assign sel_data  = write_enable && (address == ADDR_DATA);
    assign sel_ctrl  = write_enable && (address == ADDR_CTRL);
    assign flush     = sel_ctrl && write_data[0];
    assign ovf_clr   = sel_ctrl && write_data[1];
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    // Fullness is judged on the pre-edge count, so a same-cycle pop never
    // rescues a push into a full FIFO.
    assign push_ok   = sel_data && !full && !flush;
    assign push_drop = sel_data && full && !flush;
    assign pop       = (state_q == LAUNCH) && !empty;

    // Drain FSM
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        uart_we_d   = 1'b0;
        uart_data_d = uart_data_q;
        case (state_q)
            IDLE: begin
                if (!empty && !uart_busy) state_d = LAUNCH;
            end
            LAUNCH: begin
                // Count can only be zero here if a flush hit the IDLE->LAUNCH
                // edge; in that case there is nothing to send.
                if (!empty) begin
                    uart_we_d   = 1'b1;
                    uart_data_d = mem_q[head_q];
                    tmo_d       = '0;
                    state_d     = WAIT_BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_BUSY: begin
                if (uart_busy)               state_d = WAIT_IDLE;
                else if (tmo_q == TMO_LAST)  state_d = IDLE;
                else                         tmo_d   = tmo_q + 1'b1;
            end
            WAIT_IDLE: begin
                if (!uart_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; flush overrides push and pop. The launched byte was
    // already captured into uart_data_d above, so it still goes out.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) tail_d = tail_q + 1'b1;
            if (pop)     head_d = head_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (ovf_clr)   ovf_d = 1'b0;
        if (push_drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            ovf_q       <= 1'b0;
            uart_data_q <= '0;
            uart_we_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            ovf_q       <= ovf_d;
            uart_data_q <= uart_data_d;
            uart_we_q   <= uart_we_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[tail_q] <= write_data[7:0];
    end

    always_comb begin
        read_data = '0;
        if (address == ADDR_STAT) begin
            read_data[0]          = full;
            read_data[1]          = empty;
            read_data[2]          = ovf_q;
            read_data[3]          = (state_q != IDLE);
            read_data[8 +: CNT_W] = count_q;
        end
    end

    assign uart_data         = uart_data_q;
    assign uart_write_enable = uart_we_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1002_0000;
    localparam int          TMO   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic [31:0] read_data;
    logic [7:0]  uart_data;
    logic        uart_write_enable;
    logic        uart_busy = 1'b0;

    uart_tx_fifo #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .BUSY_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .write_enable(write_enable), .read_data(read_data), .uart_data(uart_data),
        .uart_write_enable(uart_write_enable), .uart_busy(uart_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: bytes accepted but not yet launched, plus sticky overflow.
    logic [7:0] exp_q[$];
    bit         mdl_ovf = 1'b0;

    int launches = 0;
    int last_launch = -100;
    int launch_cyc[$];
    bit busy_d1 = 1'b0, busy_d2 = 1'b0;

    // UART model controls
    bit stall = 1'b0, rand_mode = 1'b0;
    int busy_len = 20;
    int busy_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit drain);
        logic [31:0] s;
        s        = '0;
        s[0]     = (exp_q.size() == DEPTH);
        s[1]     = (exp_q.size() == 0);
        s[2]     = mdl_ovf;
        s[3]     = drain;
        s[16:8]  = 9'(exp_q.size());
        return s;
    endfunction

    // UART model: busy rises the cycle after a strobe and stays up busy_len cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (uart_write_enable === 1'b1)
            busy_cnt = rand_mode ? int'($urandom_range(0, 5)) : busy_len;
        else if (busy_cnt > 0)
            busy_cnt--;
        uart_busy = stall || (busy_cnt > 0);
    end

    // Monitor: every launch is popped from the scoreboard and compared.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_launch = -100;
        end else if (uart_write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_launch: got byte 0x%0h, expected no launch", uart_data);
            end else begin
                chk("launch_data", {24'h0, uart_data}, {24'h0, exp_q.pop_front()});
            end
            chk("busy_low_before_launch", {31'h0, busy_d2}, 32'h0);
            chk("launch_spacing", {31'h0, (cyc - last_launch) >= 3}, 32'h1);
            last_launch = cyc;
            launches++;
            launch_cyc.push_back(cyc);
        end
        busy_d2 = busy_d1;
        busy_d1 = uart_busy;
    end

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input int keep = 0);
        @(negedge clk);
        address = addr; write_data = data; write_enable = 1'b1;
        @(posedge clk);
        if (addr == BASE) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(data[7:0]);
            else mdl_ovf = 1'b1;
        end else if (addr == BASE + 32'd8) begin
            if (data[0]) while (exp_q.size() > keep) void'(exp_q.pop_back());
            if (data[1]) mdl_ovf = 1'b0;
        end
        #1 write_enable = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        wr(BASE, {24'h0, b});
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] d);
        @(negedge clk);
        address = addr; write_enable = 1'b0;
        #1 d = read_data;
    endtask

    task automatic check_status(input string name, input bit drain);
        logic [31:0] d;
        rd(BASE + 32'd4, d);
        chk(name, d, exp_status(drain));
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || uart_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || uart_busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d bytes pending busy=%0b, expected 0 and idle",
                     exp_q.size(), uart_busy);
            exp_q.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        int n0, pc, n, sz;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_uart_we", {31'h0, uart_write_enable}, 32'h0);
        chk("reset_uart_data", {24'h0, uart_data}, 32'h0);
        check_status("reset_status", 1'b0);
        rd(BASE, d);             chk("data_reads_zero", d, 32'h0);
        rd(BASE + 32'd8, d);     chk("ctrl_reads_zero", d, 32'h0);
        rd(BASE + 32'd12, d);    chk("unmapped_reads_zero", d, 32'h0);

        // Single byte and launch latency
        busy_len = 20;
        n0 = launches;
        push(8'h41);
        pc = cyc;
        wait_quiet(200);
        chk("single_launch_count", launches - n0, 1);
        chk("single_latency", launch_cyc[launch_cyc.size()-1] - pc, 2);
        check_status("single_status_empty", 1'b0);

        // Ordered drain with a slow UART
        n0 = launches;
        push(8'h10); push(8'h11); push(8'h12);
        wait_quiet(300);
        chk("ordered_launch_count", launches - n0, 3);
        sz = launch_cyc.size();
        chk("ordered_gap_waits_busy",
            {31'h0, (launch_cyc[sz-1] - launch_cyc[sz-2]) > busy_len}, 32'h1);

        // Overflow with the UART stalled
        stall = 1'b1;
        repeat (2) @(negedge clk);
        n0 = launches;
        for (int i = 0; i < DEPTH + 1; i++) push(8'(8'h80 + i));
        rd(BASE + 32'd4, d);
        chk("overflow_status_literal", d, 32'h0000_1005);
        check_status("overflow_status_model", 1'b0);
        wr(BASE + 32'd8, 32'h2);
        check_status("overflow_cleared", 1'b0);
        stall = 1'b0;
        wait_quiet(1000);
        chk("overflow_launch_count", launches - n0, DEPTH);

        // Wrap-around with intermittent busy (including timeouts)
        rand_mode = 1'b1;
        n0 = launches;
        for (int i = 0; i < 40; i++) begin
            n = 0;
            while (exp_q.size() >= DEPTH && n < 200) begin @(negedge clk); n++; end
            push(8'(i));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_quiet(1000);
        chk("wrap_launch_count", launches - n0, 40);
        check_status("wrap_status", 1'b0);

        // Random bytes pushed flat out; the model decides what gets dropped.
        for (int i = 0; i < 24; i++) push(8'($urandom_range(0, 255)));
        wait_quiet(1000);
        check_status("random_status", 1'b0);
        wr(BASE + 32'd8, 32'h2);
        rand_mode = 1'b0;

        // Flush in the LAUNCH cycle
        busy_len = 20;
        stall = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        n0 = launches;
        @(negedge clk) stall = 1'b0;
        @(posedge clk);
        @(posedge clk);
        wr(BASE + 32'd8, 32'h1, 1);
        check_status("flush_status_draining", 1'b1);
        wait_quiet(300);
        chk("flush_launch_count", launches - n0, 1);
        check_status("flush_status_idle", 1'b0);

        // UART never raises busy: FSM times out and moves on
        busy_len = 0;
        n0 = launches;
        push(8'h61); push(8'h62); push(8'h63);
        wait_quiet(300);
        chk("timeout_launch_count", launches - n0, 3);
        sz = launch_cyc.size();
        chk("timeout_gap1", launch_cyc[sz-2] - launch_cyc[sz-3], TMO + 2);
        chk("timeout_gap2", launch_cyc[sz-1] - launch_cyc[sz-2], TMO + 2);

        // Reset while waiting for the UART to go idle
        busy_len = 20;
        n0 = launches;
        push(8'h71); push(8'h72); push(8'h73);
        n = 0;
        while (launches == n0 && n < 50) begin @(negedge clk); n++; end
        chk("reset_test_first_launch", launches - n0, 1);
        repeat (4) @(negedge clk);
        check_status("wait_idle_status", 1'b1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        mdl_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_uart_we", {31'h0, uart_write_enable}, 32'h0);
        chk("midreset_uart_data", {24'h0, uart_data}, 32'h0);
        check_status("midreset_status", 1'b0);
        n0 = launches;
        repeat (40) @(negedge clk);
        chk("no_launch_after_reset", launches - n0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
